// File: rtl/axilite_gpio.sv
// AXI-Lite GPIO peripheral: synchronised inputs with per-bit edge interrupts,
// register-driven outputs and one level interrupt line.
module axilite_gpio #(
  parameter int NUM_GPIO_IN  = 16,
  parameter int NUM_GPIO_OUT = 16,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr_i,
  input  logic                    s_axil_awvalid_i,
  output logic                    s_axil_awready_o,
  input  logic [31:0]             s_axil_wdata_i,
  input  logic [3:0]              s_axil_wstrb_i,
  input  logic                    s_axil_wvalid_i,
  output logic                    s_axil_wready_o,
  output logic [1:0]              s_axil_bresp_o,
  output logic                    s_axil_bvalid_o,
  input  logic                    s_axil_bready_i,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr_i,
  input  logic                    s_axil_arvalid_i,
  output logic                    s_axil_arready_o,
  output logic [31:0]             s_axil_rdata_o,
  output logic [1:0]              s_axil_rresp_o,
  output logic                    s_axil_rvalid_o,
  input  logic                    s_axil_rready_i,
  input  logic [NUM_GPIO_IN-1:0]  gpio_in_i,
  output logic [NUM_GPIO_OUT-1:0] gpio_out_o,
  output logic                    irq_o
);

  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} r_state_t;

  localparam logic [2:0] A_DATA_IN  = 3'd0;
  localparam logic [2:0] A_DATA_OUT = 3'd1;
  localparam logic [2:0] A_RISE_EN  = 3'd2;
  localparam logic [2:0] A_FALL_EN  = 3'd3;
  localparam logic [2:0] A_IRQ_STAT = 3'd4;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic [NUM_GPIO_OUT-1:0] data_out_reg;
  logic [NUM_GPIO_IN-1:0]  rise_en_reg, fall_en_reg, irq_status_reg;
  logic [NUM_GPIO_IN-1:0]  sync1_reg, sync2_reg, prev_reg;
  logic [NUM_GPIO_IN-1:0]  rise, fall, irq_set, irq_clr;
  logic [1:0]              bresp_reg, rresp_reg, rresp_mux;
  logic [31:0]             rdata_reg, rdata_mux, wmask;
  logic [2:0]              waddr, raddr;
  logic                    wr_en, rd_en;
  logic                    unused_bits;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{s_axil_wstrb_i[gi]}};
    end
  endgenerate

  // Only address bits [4:2] select a register; the rest are don't-care.
  assign unused_bits = ^{s_axil_awaddr_i, s_axil_araddr_i, s_axil_wdata_i, wmask};

  assign waddr = s_axil_awaddr_i[4:2];
  assign raddr = s_axil_araddr_i[4:2];
  assign wr_en = (w_state_reg == W_ACCEPT);
  assign rd_en = (r_state_reg == R_ACCEPT);

  assign rise    = sync2_reg & ~prev_reg;
  assign fall    = ~sync2_reg & prev_reg;
  assign irq_set = (rise & rise_en_reg) | (fall & fall_en_reg);
  assign irq_clr = (wr_en && waddr == A_IRQ_STAT) ?
                   (s_axil_wdata_i[NUM_GPIO_IN-1:0] & wmask[NUM_GPIO_IN-1:0]) : '0;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      w_state_reg <= W_IDLE;
      r_state_reg <= R_IDLE;
    end else begin
      w_state_reg <= w_state_next;
      r_state_reg <= r_state_next;
    end
  end

  always_comb begin
    w_state_next     = w_state_reg;
    s_axil_awready_o = 1'b0;
    s_axil_wready_o  = 1'b0;
    s_axil_bvalid_o  = 1'b0;
    case (w_state_reg)
      W_IDLE:   if (s_axil_awvalid_i && s_axil_wvalid_i) w_state_next = W_ACCEPT;
      W_ACCEPT: begin
        s_axil_awready_o = 1'b1;
        s_axil_wready_o  = 1'b1;
        w_state_next     = W_RESP;
      end
      W_RESP: begin
        s_axil_bvalid_o = 1'b1;
        if (s_axil_bready_i) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next     = r_state_reg;
    s_axil_arready_o = 1'b0;
    s_axil_rvalid_o  = 1'b0;
    case (r_state_reg)
      R_IDLE:   if (s_axil_arvalid_i) r_state_next = R_ACCEPT;
      R_ACCEPT: begin
        s_axil_arready_o = 1'b1;
        r_state_next     = R_DATA;
      end
      R_DATA: begin
        s_axil_rvalid_o = 1'b1;
        if (s_axil_rready_i) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    rdata_mux = '0;
    rresp_mux = RESP_OKAY;
    case (raddr)
      A_DATA_IN:  rdata_mux[NUM_GPIO_IN-1:0]  = sync2_reg;
      A_DATA_OUT: rdata_mux[NUM_GPIO_OUT-1:0] = data_out_reg;
      A_RISE_EN:  rdata_mux[NUM_GPIO_IN-1:0]  = rise_en_reg;
      A_FALL_EN:  rdata_mux[NUM_GPIO_IN-1:0]  = fall_en_reg;
      A_IRQ_STAT: rdata_mux[NUM_GPIO_IN-1:0]  = irq_status_reg;
      default:    rresp_mux = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      data_out_reg   <= '0;
      rise_en_reg    <= '0;
      fall_en_reg    <= '0;
      irq_status_reg <= '0;
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      prev_reg       <= '0;
      bresp_reg      <= RESP_OKAY;
      rresp_reg      <= RESP_OKAY;
      rdata_reg      <= '0;
    end else begin
      sync1_reg <= gpio_in_i;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      // A new edge on the same cycle as a W1C clear keeps the bit set.
      irq_status_reg <= (irq_status_reg & ~irq_clr) | irq_set;
      if (wr_en) begin
        bresp_reg <= (waddr <= A_IRQ_STAT) ? RESP_OKAY : RESP_SLVERR;
        if (waddr == A_DATA_OUT)
          data_out_reg <= (data_out_reg & ~wmask[NUM_GPIO_OUT-1:0]) |
                          (s_axil_wdata_i[NUM_GPIO_OUT-1:0] & wmask[NUM_GPIO_OUT-1:0]);
        if (waddr == A_RISE_EN)
          rise_en_reg <= (rise_en_reg & ~wmask[NUM_GPIO_IN-1:0]) |
                         (s_axil_wdata_i[NUM_GPIO_IN-1:0] & wmask[NUM_GPIO_IN-1:0]);
        if (waddr == A_FALL_EN)
          fall_en_reg <= (fall_en_reg & ~wmask[NUM_GPIO_IN-1:0]) |
                         (s_axil_wdata_i[NUM_GPIO_IN-1:0] & wmask[NUM_GPIO_IN-1:0]);
      end
      if (rd_en) begin
        rdata_reg <= rdata_mux;
        rresp_reg <= rresp_mux;
      end
    end
  end

  assign s_axil_bresp_o = bresp_reg;
  assign s_axil_rdata_o = rdata_reg;
  assign s_axil_rresp_o = rresp_reg;
  assign gpio_out_o     = data_out_reg;
  assign irq_o          = |(irq_status_reg & (rise_en_reg | fall_en_reg));

endmodule

// File: tb/tb_axilite_gpio.sv
// Directed self-checking bench for axilite_gpio: register access, strobes,
// edge interrupts, SLVERR decode, handshake stalls and reset abort.
module tb_axilite_gpio;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [15:0] gpio_in, gpio_out;
  logic        irq;

  int checks = 0;
  int passes = 0;

  logic [1:0]  resp;
  logic [31:0] data;
  int          lat;

  always #5 clk = ~clk;

  axilite_gpio dut (
    .clock_i(clk), .reset_i(rst),
    .s_axil_awaddr_i(awaddr), .s_axil_awvalid_i(awvalid), .s_axil_awready_o(awready),
    .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
    .s_axil_wready_o(wready),
    .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
    .s_axil_araddr_i(araddr), .s_axil_arvalid_i(arvalid), .s_axil_arready_o(arready),
    .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
    .s_axil_rready_i(rready),
    .gpio_in_i(gpio_in), .gpio_out_o(gpio_out), .irq_o(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Starts just after a rising edge; returns just after the edge that retires the response.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] strb,
                           input int aw_lead, input int hold,
                           output logic [1:0] r, output int l);
    logic hs = 1'b0;
    awaddr = addr; wdata = d; wstrb = strb;
    awvalid = 1'b1; wvalid = (aw_lead == 0); bready = (hold == 0);
    for (int k = 0; k < aw_lead; k++) begin
      @(negedge clk); check("aw_alone_awready", awready, 0);
      @(posedge clk); #1;
    end
    wvalid = 1'b1;
    l = 0;
    r = 2'b11;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bvalid) break;
      if (awready) hs = 1'b1;
      @(posedge clk); #1; l++;
      if (hs) begin awvalid = 1'b0; wvalid = 1'b0; end
    end
    if (!bvalid) begin
      check("bvalid_timeout", 0, 1);
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
      return;
    end
    r = bresp;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bvalid_held", bvalid, 1);
      check("bresp_held", bresp, r);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    $display("WR addr=0x%02h data=0x%08h strb=%b bresp=%b lat=%0d", addr, d, strb, r, l);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] d,
                          output logic [1:0] r, output int l);
    logic hs = 1'b0;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    l = 0; d = '0; r = 2'b11;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rvalid) break;
      if (arready) hs = 1'b1;
      @(posedge clk); #1; l++;
      if (hs) arvalid = 1'b0;
    end
    if (!rvalid) begin
      check("rvalid_timeout", 0, 1);
      arvalid = 1'b0;
      return;
    end
    d = rdata; r = rresp;
    @(posedge clk); #1;
    $display("RD addr=0x%02h data=0x%08h rresp=%b lat=%0d", addr, d, r, l);
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0; gpio_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_resps", {bresp, rresp}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_gpio_out", gpio_out, 0);
    check("rst_irq", irq, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Strobed write, latency, readback
    axi_write(32'h04, 32'h0000A5A5, 4'b0011, 0, 0, resp, lat);
    check("wr_a5_bresp", resp, 2'b00);
    check("wr_latency", lat, 2);
    check("wr_a5_gpio_out", gpio_out, 16'hA5A5);
    axi_read(32'h04, data, resp, lat);
    check("rd_a5_data", data, 32'h0000A5A5);
    check("rd_a5_rresp", resp, 2'b00);
    check("rd_latency", lat, 2);

    axi_write(32'h04, 32'h0, 4'b1111, 0, 0, resp, lat);
    axi_write(32'h04, 32'hFFFFFFFF, 4'b0001, 0, 0, resp, lat);
    check("wr_strb0001_gpio_out", gpio_out, 16'h00FF);
    axi_write(32'h04, 32'hFFFFFFFF, 4'b1000, 0, 0, resp, lat);
    check("wr_strb1000_gpio_out", gpio_out, 16'h00FF);
    axi_write(32'h08, 32'hFFFFFFFF, 4'b1111, 0, 0, resp, lat);
    axi_read(32'h08, data, resp, lat);
    check("rd_rise_en_upper_zero", data, 32'h0000FFFF);

    // Rising-edge interrupt on bit 0
    axi_write(32'h08, 32'h1, 4'b1111, 0, 0, resp, lat);
    gpio_in = 16'h0001;
    @(posedge clk); #1;
    @(negedge clk); check("irq_after_e0", irq, 0);
    @(posedge clk); #1;
    @(negedge clk); check("irq_after_e1", irq, 0);
    @(posedge clk); #1;
    @(negedge clk); check("irq_after_e2", irq, 1);
    @(posedge clk); #1;
    axi_read(32'h10, data, resp, lat);
    check("rd_status_rise", data, 32'h1);
    axi_read(32'h00, data, resp, lat);
    check("rd_data_in_bit0", data, 32'h1);
    axi_write(32'h10, 32'h1, 4'b1111, 0, 0, resp, lat);
    @(negedge clk); check("irq_after_w1c", irq, 0);
    @(posedge clk); #1;

    // Set and W1C on the same edge: set wins
    gpio_in = 16'h0000;
    repeat (4) @(posedge clk);
    #1;
    gpio_in = 16'h0001;
    @(posedge clk); #1;
    axi_write(32'h10, 32'h1, 4'b1111, 0, 0, resp, lat);
    @(negedge clk); check("irq_set_beats_clear", irq, 1);
    @(posedge clk); #1;
    axi_read(32'h10, data, resp, lat);
    check("rd_status_set_beats_clear", data, 32'h1);
    axi_write(32'h10, 32'h1, 4'b1111, 0, 0, resp, lat);
    axi_read(32'h10, data, resp, lat);
    check("rd_status_cleared", data, 32'h0);

    // Falling-edge interrupt on bit 1 with a 2-cycle low pulse
    axi_write(32'h0C, 32'h2, 4'b1111, 0, 0, resp, lat);
    gpio_in = 16'h0003;
    repeat (4) @(posedge clk);
    #1;
    axi_read(32'h10, data, resp, lat);
    check("rd_status_no_rise_en_bit1", data, 32'h0);
    gpio_in = 16'h0001;
    repeat (2) @(posedge clk);
    #1;
    gpio_in = 16'h0003;
    repeat (4) @(posedge clk);
    #1;
    axi_read(32'h10, data, resp, lat);
    check("rd_status_fall", data, 32'h2);
    @(negedge clk); check("irq_fall", irq, 1);
    @(posedge clk); #1;
    axi_read(32'h00, data, resp, lat);
    check("rd_data_in_both", data, 32'h3);
    axi_write(32'h10, 32'h2, 4'b1111, 0, 0, resp, lat);

    // Unmapped address
    axi_read(32'h18, data, resp, lat);
    check("rd_unmapped_data", data, 32'h0);
    check("rd_unmapped_rresp", resp, 2'b10);
    axi_write(32'h18, 32'hFFFFFFFF, 4'b1111, 0, 0, resp, lat);
    check("wr_unmapped_bresp", resp, 2'b10);
    check("wr_unmapped_gpio_out", gpio_out, 16'h00FF);
    axi_read(32'h08, data, resp, lat);
    check("wr_unmapped_rise_en", data, 32'h1);
    axi_read(32'h0C, data, resp, lat);
    check("wr_unmapped_fall_en", data, 32'h2);

    // AW ahead of W, then a stalled response
    axi_write(32'h04, 32'h00001234, 4'b1111, 4, 5, resp, lat);
    check("wr_stall_bresp", resp, 2'b00);
    @(negedge clk);
    check("wr_stall_bvalid_done", bvalid, 0);
    check("wr_stall_gpio_out", gpio_out, 16'h1234);
    @(posedge clk); #1;

    // Reset while rvalid is held
    begin
      logic hs = 1'b0;
      araddr = 32'h04; arvalid = 1'b1; rready = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (rvalid) break;
        if (arready) hs = 1'b1;
        @(posedge clk); #1;
        if (hs) arvalid = 1'b0;
      end
      arvalid = 1'b0;
      check("rd_pending_rvalid", rvalid, 1);
      check("rd_pending_rdata", rdata, 32'h00001234);
      $display("RD addr=0x04 data=0x%08h pending, reset asserted", rdata);
      rst = 1'b1;
      #1;
      check("rst_mid_read_rvalid", rvalid, 0);
      check("rst_mid_read_gpio_out", gpio_out, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      rready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("no_resp_after_reset", rvalid, 0);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axilite_gpio.md
# axilite_gpio

Parametrised GPIO peripheral for the AXI-Lite peripheral bus. It is the register-mapped successor to the fixed 16-in/16-out SoC GPIO constants. Input and output widths are set independently by parameters. Inputs pass through a two-flop synchroniser, and each input bit can raise an interrupt on its rising and/or falling edge. The block occupies one peripheral-bus slave slot and drives one level interrupt line to the core.

## Interface
Parameters:
- NUM_GPIO_IN, 16, number of input pins; legal range 1..32.
- NUM_GPIO_OUT, 16, number of output pins; legal range 1..32.
- ADDR_WIDTH, 32, AXI-Lite address width. Only bits [4:2] are decoded.

Ports:
- clock_i  in  1  system clock; all logic is on its rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- s_axil_awaddr_i / awvalid_i / awready_o  in/in/out  ADDR_WIDTH/1/1  write-address channel.
- s_axil_wdata_i / wstrb_i / wvalid_i / wready_o  in/in/in/out  32/4/1/1  write-data channel.
- s_axil_bresp_o / bvalid_o / bready_i  out/out/in  2/1/1  write-response channel.
- s_axil_araddr_i / arvalid_i / arready_o  in/in/out  ADDR_WIDTH/1/1  read-address channel.
- s_axil_rdata_o / rresp_o / rvalid_o / rready_i  out/out/out/in  32/2/1/1  read-data channel.
- gpio_in_i  in  NUM_GPIO_IN  asynchronous input pins.
- gpio_out_o  out  NUM_GPIO_OUT  output pins, driven by a register.
- irq_o  out  1  level interrupt, equal to |(IRQ_STATUS & IRQ_EN), where IRQ_EN = RISE_EN | FALL_EN per bit.

## Operation
Register map (byte offsets). Unused upper bits read 0 and ignore writes.
- 0x00 DATA_IN, read-only: synchronised inputs, zero-extended.
- 0x04 DATA_OUT, read/write: drives gpio_out_o.
- 0x08 RISE_EN, read/write: per-input rising-edge interrupt enable.
- 0x0C FALL_EN, read/write: per-input falling-edge interrupt enable.
- 0x10 IRQ_STATUS, read / write-1-to-clear.
- 0x14..0x1C: unmapped. Reads return 0 with rresp=SLVERR (2'b10); writes are ignored with bresp=SLVERR. Mapped accesses return OKAY (2'b00).

Write byte strobes:
- wstrb byte-masks writes to DATA_OUT, RISE_EN, FALL_EN and the W1C mask of IRQ_STATUS.

Synchroniser and edge detect:
- Chain per input: sync1 <= gpio_in_i; sync2 <= sync1; prev <= sync2.
- rise = sync2 & ~prev; fall = ~sync2 & prev.
- Status bit i is set on the clock edge where (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]) holds.
- If a set and a W1C clear of the same bit occur on the same edge, the set wins.

Write FSM:
- W_IDLE: awready=wready=0. Moves to W_ACCEPT only when awvalid and wvalid are both high. AW or W arriving alone waits in W_IDLE.
- W_ACCEPT: awready=wready=1 for exactly one cycle. The register is updated on the closing edge; then moves to W_RESP.
- W_RESP: bvalid=1, bresp held stable until bready is high at a clock edge; then returns to W_IDLE.

Read FSM (independent of the write FSM):
- R_IDLE: moves to R_ACCEPT when arvalid is high.
- R_ACCEPT: arready=1 for one cycle. rdata/rresp are captured on the closing edge; then moves to R_DATA.
- R_DATA: rvalid=1 with rdata stable until rready is high at an edge; then returns to R_IDLE.
- A read captured on the same edge as a write to the same register returns the pre-write value.

## Timing
- Reset: every output is 0 (awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, gpio_out_o, irq_o). All registers, sync flops and prev are 0. Both FSMs are idle.
- Reset asserted mid-transaction aborts it immediately and drops all valids and readys. No response is produced after reset is released.
- Write latency: with valids high from cycle 0, ready is high in cycle 1 and bvalid is first high in cycle 2. gpio_out_o changes in cycle 2.
- Read latency: with arvalid high from cycle 0, arready is high in cycle 1 and rvalid is first high in cycle 2.
- Back-to-back: minimum 3 cycles per transaction per channel when bready/rready are held high.
- Input latency: a pin change sampled at edge E0 reaches DATA_IN after edge E1. IRQ_STATUS and irq_o update after edge E2.
- Input pulses must be at least 2 clocks wide to be seen.
- After reset, a pin held high yields a rise at E1. It sets status only if RISE_EN is already 1, which cannot happen while the block is in reset.

## Test plan
- Reset, then write 0xA5A5 to 0x04 with wstrb=4'b0011 -> bresp=OKAY in cycle 2; gpio_out_o=0xA5A5; read of 0x04 returns 0x0000A5A5.
- Write 0xFFFFFFFF to 0x04 with wstrb=4'b0001 starting from DATA_OUT=0 -> gpio_out_o=0x00FF.
- RISE_EN=0x1, then gpio_in_i[0] goes 0->1 -> irq_o high 3 edges later; IRQ_STATUS reads 0x1. Write 0x1 to 0x10 -> irq_o low. Same-edge set and clear of the bit -> bit stays 1.
- FALL_EN=0x2, then pulse gpio_in_i[1] 1->0 -> status 0x2. A 1-cycle glitch may be missed; a 2-cycle pulse must be caught.
- Read of 0x18 -> rdata=0, rresp=2'b10. Write to 0x18 -> bresp=2'b10 and no register changes.
- AW presented 4 cycles before W -> awready stays 0 until W arrives. Hold bready=0 for 5 cycles -> bvalid and bresp stay stable. Assert reset mid-R_DATA -> rvalid drops immediately.
